regfile_ctx_engine: RTL and testbench

- Context save/restore sequencer on the client side of the 16x32 register file.
- Save: reads the selected registers through one read port and streams them out on a valid/ready interface.
- Restore: accepts a valid/ready stream and writes it into the selected registers through the write port.
- Used for task switch and debug dump/load. While busy=1, the surrounding mux gives the engine the register file's write port and read port A.

---
 rtl/regfile_ctx_engine.sv | 154 +++++++++++++++
 tb/tb_regfile_ctx_engine.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctx_engine.sv
// regfile_ctx_engine
// Context save/restore sequencer for the 2^N x S register file.
// A save reads the selected registers through read port A and streams them
// out in ascending index order. A restore writes an incoming stream into the
// selected registers through the write port. While busy is high the
// surrounding mux hands both of those ports to this engine.
module regfile_ctx_engine #(
  parameter int N = 4,
  parameter int S = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_op,
  input  logic [2**N-1:0] cmd_mask,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    rf_rA,
  input  logic [S-1:0]    rf_A,
  output logic            rf_wr,
  output logic [N-1:0]    rf_rD,
  output logic [S-1:0]    rf_D,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [S-1:0]    out_data,
  output logic [N-1:0]    out_idx,
  output logic            out_last,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [S-1:0]    in_data
);

  localparam int R = 2**N;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Registers still to be processed; one bit per register index.
  logic [R-1:0] rem;
  logic [R-1:0] rem_clr;
  logic [R-1:0] cur_onehot;
  logic [N-1:0] cur_idx;
  logic         load;
  logic         beat_out;
  logic         beat_in;

  // Priority encoder: lowest set bit of rem wins, 0 when rem is empty.
  always_comb begin
    cur_idx = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (rem[i]) cur_idx = N'(i);
    end
  end

  // One-hot of the current index, used to retire that register from rem.
  for (genvar gi = 0; gi < R; gi++) begin : g_onehot
    assign cur_onehot[gi] = (cur_idx == N'(gi));
  end

  assign rem_clr  = rem & ~cur_onehot;

  // A new save beat is fetched whenever the output slot is empty or draining.
  assign load     = (state == SAVE) && (!out_valid || out_ready) && (rem != '0);
  assign beat_out = out_valid && out_ready;
  assign beat_in  = (state == RESTORE) && in_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_mask == '0) state_next = DONE;
          else if (!cmd_op)   state_next = SAVE;
          else                state_next = RESTORE;
        end
      end
      SAVE: begin
        if (beat_out && out_last) state_next = DONE;
      end
      RESTORE: begin
        if (beat_in && (rem_clr == '0)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Work mask and the registered save-stream output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) rem <= cmd_mask;
        end
        SAVE: begin
          if (load) begin
            out_data  <= rf_A;
            out_idx   <= cur_idx;
            out_last  <= (rem_clr == '0);
            out_valid <= 1'b1;
            rem       <= rem_clr;
          end else if (beat_out) begin
            out_valid <= 1'b0;
          end
        end
        RESTORE: begin
          if (in_valid) rem <= rem_clr;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // State-decoded outputs and register-file port drive.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    in_ready  = (state == RESTORE);
    rf_wr     = beat_in;
    rf_rA     = (state == SAVE) ? cur_idx : '0;
  end

  // The write index always tracks the next register to fill; data is the
  // incoming beat itself, so a write lands on the edge it is presented.
  assign rf_rD = cur_idx;
  assign rf_D  = in_data;

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// tb_regfile_ctx_engine
// Bench for the context save/restore sequencer. Owns a 16x32 register file
// model driven by the engine's ports, and a transaction-level reference that
// tracks the ordered list of registers still owed for the active command.
module tb_regfile_ctx_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [15:0] cmd_mask;
  logic        busy;
  logic        done;
  logic [3:0]  rf_rA;
  logic [31:0] rf_A;
  logic        rf_wr;
  logic [3:0]  rf_rD;
  logic [31:0] rf_D;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  regfile_ctx_engine #(.N(4), .S(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_mask(cmd_mask),
    .busy(busy), .done(done),
    .rf_rA(rf_rA), .rf_A(rf_A), .rf_wr(rf_wr), .rf_rD(rf_rD), .rf_D(rf_D),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  // Register file seen by the engine: combinational read, write on the edge.
  logic [31:0] rf_mem [16];
  logic        preload;
  assign rf_A = rf_mem[rf_rA];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 32'h11111111 * i;
    end else if (rf_wr) begin
      rf_mem[rf_rD] <= rf_D;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase of the command and the ordered owed-register list.
  int          m_phase = 0;   // 0 idle, 1 save, 2 restore, 3 done
  int          m_pend[$];
  logic [31:0] mdl_rf [16];

  // Observations for the directed checks.
  bit          mon_en = 1'b0;
  int          acc_cnt = 0, acc_cyc = 0;
  int          done_cnt = 0, done_cyc = 0;
  int          hs_cnt = 0, last_cnt = 0, wr_cnt = 0;
  int          first_valid_cyc = -1, last_beat_cyc = 0;
  int          hs_idx [64];
  logic [31:0] hs_data [64];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_idx;
  logic        prev_last;

  // Compare process: every cycle, DUT outputs against the reference, then
  // advance the reference by what the coming clock edge will do.
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mdl_rf[i] = 32'h11111111 * i;
    end
    if (mon_en) begin
      check("busy", busy, m_phase != 0);
      check("cmd_ready", cmd_ready, m_phase == 0);
      check("done", done, m_phase == 3);
      check("in_ready", in_ready, m_phase == 2);
      check("rf_wr", rf_wr, (m_phase == 2) && in_valid);
      if (m_phase != 1) check("out_valid_quiet", out_valid, 0);
      if (m_phase == 1) begin
        check("beat_with_work", out_valid && (m_pend.size() == 0), 0);
        if (out_valid && m_pend.size() > 0) begin
          check("out_idx", out_idx, m_pend[0]);
          check("out_data", out_data, mdl_rf[m_pend[0]]);
          check("out_last", out_last, m_pend.size() == 1);
        end
      end
      if (m_phase == 2) begin
        check("write_with_work", rf_wr && (m_pend.size() == 0), 0);
        if (rf_wr && m_pend.size() > 0) begin
          check("rf_rD", rf_rD, m_pend[0]);
          check("rf_D", rf_D, in_data);
        end
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_idx", out_idx, prev_idx);
        check("stall_last", out_last, prev_last);
      end
      prev_stall = out_valid && !out_ready && !reset;
      prev_data  = out_data;
      prev_idx   = out_idx;
      prev_last  = out_last;

      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end

      if (reset) begin
        m_phase = 0;
        m_pend.delete();
      end else begin
        if (rf_wr) wr_cnt++;
        case (m_phase)
          0: if (cmd_valid) begin
            acc_cnt++;
            acc_cyc = cyc;
            for (int i = 0; i < 16; i++) if (cmd_mask[i]) m_pend.push_back(i);
            m_phase = (m_pend.size() == 0) ? 3 : (cmd_op ? 2 : 1);
            $display("cmd op=%0d mask=%h accepted cycle %0d", cmd_op, cmd_mask, cyc);
          end
          1: if (out_valid && out_ready && m_pend.size() > 0) begin
            if (hs_cnt < 64) begin
              hs_idx[hs_cnt]  = out_idx;
              hs_data[hs_cnt] = out_data;
            end
            hs_cnt++;
            if (out_last) last_cnt++;
            last_beat_cyc = cyc;
            void'(m_pend.pop_front());
            if (m_pend.size() == 0) m_phase = 3;
            $display("save beat idx=%0d data=%h last=%0b", out_idx, out_data, out_last);
          end
          2: if (in_valid && m_pend.size() > 0) begin
            mdl_rf[m_pend[0]] = in_data;
            $display("restore write idx=%0d data=%h", m_pend[0], in_data);
            void'(m_pend.pop_front());
            if (m_pend.size() == 0) m_phase = 3;
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic issue(input logic op, input logic [15:0] mask, output int acc);
    int start = acc_cnt;
    int n = 0;
    cmd_op = op;
    cmd_mask = mask;
    cmd_valid = 1'b1;
    while (acc_cnt == start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", acc_cnt != start, 1);
    acc = acc_cyc;
  endtask

  task automatic wait_done(input int start, input bit toggle);
    int n = 0;
    while (done_cnt <= start && n < 200) begin
      @(posedge clk); #1;
      if (toggle) out_ready = !out_ready;
      n++;
    end
    check("done_seen", done_cnt > start, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a, ds, hs0, wr0, a0, n;
    reset = 1'b1; preload = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_mask = '0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; preload = 1'b0; mon_en = 1'b1;

    // Reset values.
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_rf_wr", rf_wr, 0);
    check("rst_in_ready", in_ready, 0);

    // Full save, sink always ready: 16 back-to-back beats.
    out_ready = 1'b1; first_valid_cyc = -1; hs0 = hs_cnt; last_cnt = 0;
    ds = done_cnt;
    issue(1'b0, 16'hFFFF, a);
    wait_done(ds, 1'b0);
    check("t1_first_valid_cyc", first_valid_cyc, a + 2);
    check("t1_beats", hs_cnt - hs0, 16);
    check("t1_contiguous", last_beat_cyc - first_valid_cyc, 15);
    check("t1_idx0", hs_idx[hs0], 0);
    check("t1_data1", hs_data[hs0 + 1], 32'h11111111);
    check("t1_idx15", hs_idx[hs0 + 15], 15);
    check("t1_data15", hs_data[hs0 + 15], 32'hFFFFFFFF);
    check("t1_last_count", last_cnt, 1);
    check("t1_done_cyc", done_cyc, last_beat_cyc + 1);

    // Sparse save with sink toggling.
    hs0 = hs_cnt; last_cnt = 0; ds = done_cnt;
    issue(1'b0, 16'h8005, a);
    wait_done(ds, 1'b1);
    out_ready = 1'b1;
    check("t2_beats", hs_cnt - hs0, 3);
    check("t2_idx0", hs_idx[hs0], 0);
    check("t2_idx1", hs_idx[hs0 + 1], 2);
    check("t2_idx2", hs_idx[hs0 + 2], 15);
    check("t2_data1", hs_data[hs0 + 1], 32'h22222222);
    check("t2_last_count", last_cnt, 1);

    // Restore two registers with a two-cycle gap in the input stream.
    wr0 = wr_cnt; ds = done_cnt;
    issue(1'b1, 16'h0090, a);
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t3_gap_writes", wr_cnt - wr0, 1);
    in_valid = 1'b1; in_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(ds, 1'b0);
    check("t3_writes", wr_cnt - wr0, 2);
    check("t3_reg4", rf_mem[4], 32'hDEADBEEF);
    check("t3_reg7", rf_mem[7], 32'hCAFEF00D);
    check("t3_reg9", rf_mem[9], 32'h99999999);
    // A surplus beat after completion must not be taken.
    in_valid = 1'b1; in_data = 32'h55555555;
    @(posedge clk); #1;
    check("t3_in_ready_after", in_ready, 0);
    check("t3_no_surplus", wr_cnt - wr0, 2);
    in_valid = 1'b0;

    // Empty mask, both ops.
    for (int op = 0; op < 2; op++) begin
      hs0 = hs_cnt; wr0 = wr_cnt; ds = done_cnt;
      issue(op[0], 16'h0000, a);
      wait_done(ds, 1'b0);
      check("t4_done_cyc", done_cyc, a + 1);
      check("t4_no_beats", hs_cnt - hs0, 0);
      check("t4_no_writes", wr_cnt - wr0, 0);
      check("t4_cmd_ready", cmd_ready, 1);
    end

    // Reset in the middle of a save after three beats.
    out_ready = 1'b1; hs0 = hs_cnt;
    issue(1'b0, 16'hFFFF, a);
    n = 0;
    while (hs_cnt < hs0 + 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_three_beats", hs_cnt - hs0, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_out_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_aborted", hs_cnt - hs0, 3);
    wr0 = wr_cnt; ds = done_cnt;
    issue(1'b1, 16'h0003, a);
    in_valid = 1'b1; in_data = 32'h0BADF00D;
    @(posedge clk); #1;
    in_data = 32'h12345678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(ds, 1'b0);
    check("t5_writes", wr_cnt - wr0, 2);
    check("t5_reg0", rf_mem[0], 32'h0BADF00D);
    check("t5_reg1", rf_mem[1], 32'h12345678);

    // cmd_valid held high while busy: second command waits for done.
    out_ready = 1'b1; ds = done_cnt; a0 = acc_cnt; hs0 = hs_cnt;
    cmd_op = 1'b0; cmd_mask = 16'h0002; cmd_valid = 1'b1;
    n = 0;
    while (acc_cnt < a0 + 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("t6_accepts", acc_cnt - a0, 2);
    check("t6_one_done_between", done_cnt - ds, 1);
    check("t6_accept_after_done", acc_cyc, done_cyc + 1);
    wait_done(ds + 1, 1'b0);
    check("t6_beats", hs_cnt - hs0, 2);
    check("t6_cmd_ready", cmd_ready, 1);

    // Register file contents against the reference.
    for (int i = 0; i < 16; i++) check("final_rf", rf_mem[i], mdl_rf[i]);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
